// File: rtl/ebox_mbox_req_if.sv
// ebox_mbox_req_if: EBOX handshake and single-outstanding backing-memory port bundle
interface ebox_mbox_req_if #(parameter int ADR_W = 23);
  logic             EBOX_REQ;
  logic [ADR_W-1:0] EBOX_VMA;
  logic             eboxRead;
  logic             eboxWrite;
  logic [35:0]      cacheDataWrite;
  logic [35:0]      cacheDataRead;
  logic             mboxRespIn;
  logic             cshEBOXT0;
  logic             cshEBOXRetry;
  logic             mbParErr;
  logic             nxmErr;
  logic             errClr;
  logic             memReq;
  logic             memWrite;
  logic [ADR_W-1:0] memAdr;
  logic [35:0]      memWData;
  logic             memAck;
  logic [35:0]      memRData;
  logic             memRPar;
  modport slave (
    input  EBOX_REQ, EBOX_VMA, eboxRead, eboxWrite, cacheDataWrite, errClr, memAck, memRData, memRPar,
    output cacheDataRead, mboxRespIn, cshEBOXT0, cshEBOXRetry, mbParErr, nxmErr, memReq, memWrite, memAdr, memWData
  );
  modport master (
    output EBOX_REQ, EBOX_VMA, eboxRead, eboxWrite, cacheDataWrite, errClr, memAck, memRData, memRPar,
    input  cacheDataRead, mboxRespIn, cshEBOXT0, cshEBOXRetry, mbParErr, nxmErr, memReq, memWrite, memAdr, memWData
  );
endinterface

// File: rtl/ebox_mbox_req.sv
// ebox_mbox_req: EBOX memory request sequencer with posted one-entry write buffer and RPW lock; PARITY_CHECK_EN enables read parity checking
module ebox_mbox_req #(
  parameter int NXM_TIMEOUT = 64,
  parameter int ADR_W = 23
) (
  input logic            clk,
  input logic            CROBAR,
  ebox_mbox_req_if.slave b
);
  typedef enum logic [2:0] {IDLE, ACCEPT, RD_REQ, RD_WAIT, RESP, RPW_HOLD, WB_DRAIN} state_t;
  localparam logic [7:0] TO_CNT = 8'(NXM_TIMEOUT);
  state_t state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d, wb_adr_q, wb_adr_d;
  logic [35:0] dat_q, dat_d, wb_dat_q, wb_dat_d, rdat_q, rdat_d;
  logic [7:0] cnt_q, cnt_d;
  logic rd_q, rd_d, wr_q, wr_d, lock_q, lock_d, wb_full_q, wb_full_d, dr_act_q, dr_act_d;
  logic retry_q, retry_d, nxm_q, nxm_d, par_q, par_d;
  logic rd_state, rd_own, mem_req, to, wb_load, req_v, par_bad;
`ifdef PARITY_CHECK_EN
  assign par_bad = rd_own && b.memAck && !(^{b.memRData, b.memRPar});
`else
  logic unused_par;
  assign unused_par = b.memRPar;
  assign par_bad = 1'b0;
`endif
  always_comb begin
    rd_state = state_q == RD_REQ || state_q == RD_WAIT;
    rd_own = rd_state && !dr_act_q;
    mem_req = rd_own || dr_act_q;
    to = mem_req && !b.memAck && cnt_q == TO_CNT;
    wb_load = (state_q == ACCEPT && wr_q && !rd_q && !lock_q) || state_q == WB_DRAIN;
    req_v = b.EBOX_REQ && (b.eboxRead || b.eboxWrite);
  end
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    dat_d = dat_q;
    rd_d = rd_q;
    wr_d = wr_q;
    lock_d = lock_q;
    rdat_d = rdat_q;
    retry_d = 1'b0;
    wb_full_d = wb_full_q;
    wb_adr_d = wb_adr_q;
    wb_dat_d = wb_dat_q;
    dr_act_d = dr_act_q;
    cnt_d = mem_req && !b.memAck && !to ? cnt_q + 8'd1 : 8'd0;
    nxm_d = to || (nxm_q && !b.errClr);
    par_d = par_bad || (par_q && !b.errClr);
    // drain owns the port until its ack; it only starts while no read holds the port
    if (dr_act_q && (b.memAck || to)) begin
      dr_act_d = 1'b0;
      wb_full_d = 1'b0;
    end else if (!dr_act_q && wb_full_q && !rd_state)
      dr_act_d = 1'b1;
    if (wb_load) begin
      wb_full_d = 1'b1;
      wb_adr_d = adr_q;
      wb_dat_d = dat_q;
    end
    case (state_q)
      IDLE: if (req_v) begin
        retry_d = wb_full_q;
        if (!wb_full_q) begin
          state_d = ACCEPT;
          adr_d = b.EBOX_VMA;
          dat_d = b.cacheDataWrite;
          rd_d = b.eboxRead;
          wr_d = b.eboxWrite;
        end
      end
      ACCEPT: state_d = rd_q ? RD_REQ : lock_q ? WB_DRAIN : IDLE;
      RD_REQ, RD_WAIT: if (rd_own) begin
        state_d = b.memAck || to ? RESP : RD_WAIT;
        rdat_d = b.memAck ? b.memRData : to ? 36'd0 : rdat_q;
      end
      RESP: begin
        state_d = rd_q && wr_q ? RPW_HOLD : IDLE;
        lock_d = rd_q && wr_q;
      end
      RPW_HOLD: if (req_v) begin
        retry_d = wb_full_q || b.eboxRead || b.EBOX_VMA != adr_q;
        if (!retry_d) begin
          state_d = ACCEPT;
          dat_d = b.cacheDataWrite;
          rd_d = 1'b0;
          wr_d = 1'b1;
        end
      end
      WB_DRAIN: begin
        state_d = IDLE;
        lock_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state_q <= IDLE;
      adr_q <= '0;
      dat_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      lock_q <= 1'b0;
      rdat_q <= '0;
      retry_q <= 1'b0;
      wb_full_q <= 1'b0;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      dr_act_q <= 1'b0;
      cnt_q <= '0;
      nxm_q <= 1'b0;
      par_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      lock_q <= lock_d;
      rdat_q <= rdat_d;
      retry_q <= retry_d;
      wb_full_q <= wb_full_d;
      wb_adr_q <= wb_adr_d;
      wb_dat_q <= wb_dat_d;
      dr_act_q <= dr_act_d;
      cnt_q <= cnt_d;
      nxm_q <= nxm_d;
      par_q <= par_d;
    end
  end
  assign b.cshEBOXT0 = state_q == ACCEPT;
  assign b.mboxRespIn = state_q == RESP || wb_load;
  assign b.cshEBOXRetry = retry_q;
  assign b.cacheDataRead = rdat_q;
  assign b.mbParErr = par_q;
  assign b.nxmErr = nxm_q;
  assign b.memReq = mem_req;
  assign b.memWrite = dr_act_q;
  assign b.memAdr = dr_act_q ? wb_adr_q : adr_q;
  assign b.memWData = wb_dat_q;
endmodule
